// File: rtl/spi_slave_regbank.sv
// SPI slave exposing a bank of 2^ADDR_W 8-bit registers.
//
// A frame starts on nss falling. The first byte is a command:
// bit7 = 1 for write, 0 for read, and bits[ADDR_W-1:0] = start address.
// Every following byte writes to, or reads from, the current address.
// The address then increments and wraps at the top of the bank.
// All SPI inputs are resynchronized into clk. SPI mode and bit order are
// latched when the frame starts.
//
// Ports
//   clk, rst          system clock; asynchronous active-high reset
//   sclk, nss, mosi   SPI bus from the master (asynchronous to clk)
//   miso, miso_oe     serial data to the master and its drive enable
//   cpol, cpha, lsbf  SPI mode and bit order, latched at frame start
//   regs              flattened register file, register k at [8k+7:8k]
//   wr_stb/addr/data  one-clk pulse describing each committed write
//   busy              frame in progress (state machine not idle)
module spi_slave_regbank #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       nss,
  input  logic                       mosi,
  output logic                       miso,
  output logic                       miso_oe,
  input  logic                       cpol,
  input  logic                       cpha,
  input  logic                       lsbf,
  output logic [8*(1<<ADDR_W)-1:0]   regs,
  output logic                       wr_stb,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [7:0]                 wr_data,
  output logic                       busy
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_nss_sync, r_mosi_sync;
  logic                   r_sclk_prev, r_nss_prev;
  state_t                 r_state;
  logic                   r_cpol, r_cpha, r_lsbf;
  logic [2:0]             r_bitcnt;
  logic [7:0]             r_rx, r_tx;
  logic                   r_is_wr;
  logic [ADDR_W-1:0]      r_addr;
  logic [NREG-1:0][7:0]   r_regs;
  logic                   r_miso, r_miso_oe, r_busy, r_wr_stb;
  logic [ADDR_W-1:0]      r_wr_addr;
  logic [7:0]             r_wr_data;

  logic w_sclk, w_nss, w_mosi;
  logic w_sclk_rise, w_sclk_fall, w_nss_fall, w_nss_rise;
  logic w_lead, w_trail, w_sample, w_shift;
  logic [7:0] w_rx_next, w_tx_shifted;
  logic w_tx_bit;
  logic [ADDR_W-1:0] w_cmd_addr, w_addr_inc;

  // Synchronizers clear to 0. The nss edge detector also starts from 0.
  // If nss is already low when rst is released, no falling edge is seen.
  // That frame is then ignored until nss goes high and falls again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_nss_sync  <= '0;
      r_mosi_sync <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_nss_sync  <= {r_nss_sync[SYNC_STAGES-2:0],  nss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_nss  = r_nss_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk & r_sclk_prev;
  assign w_nss_fall  = ~w_nss & r_nss_prev;
  assign w_nss_rise  = w_nss & ~r_nss_prev;

  // The leading edge leaves the idle level set by cpol.
  // The sample and change edges swap with cpha.
  assign w_lead   = r_cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail  = r_cpol ? w_sclk_rise : w_sclk_fall;
  assign w_sample = r_cpha ? w_trail : w_lead;
  assign w_shift  = r_cpha ? w_lead  : w_trail;

  assign w_rx_next    = r_lsbf ? {w_mosi, r_rx[7:1]} : {r_rx[6:0], w_mosi};
  assign w_tx_bit     = r_lsbf ? r_tx[0] : r_tx[7];
  assign w_tx_shifted = r_lsbf ? {1'b0, r_tx[7:1]} : {r_tx[6:0], 1'b0};
  assign w_cmd_addr   = w_rx_next[ADDR_W-1:0];
  assign w_addr_inc   = r_addr + ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_prev <= 1'b0;
      r_nss_prev  <= 1'b0;
      r_state     <= ST_IDLE;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_lsbf      <= 1'b0;
      r_bitcnt    <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_is_wr     <= 1'b0;
      r_addr      <= '0;
      r_regs      <= '0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_stb    <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_sclk_prev <= w_sclk;
      r_nss_prev  <= w_nss;
      r_wr_stb    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_nss_fall) begin
            r_state   <= ST_CMD;
            r_busy    <= 1'b1;
            r_miso_oe <= 1'b1;
            r_cpol    <= cpol;
            r_cpha    <= cpha;
            r_lsbf    <= lsbf;
            r_bitcnt  <= '0;
            r_tx      <= '0;      // command byte answers with zeros
            r_miso    <= 1'b0;
          end
        end
        default: begin
          if (w_nss_rise) begin
            // Any partial byte is dropped here and never committed.
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_miso_oe <= 1'b0;
            r_miso    <= 1'b0;
          end else begin
            if (w_shift) begin
              r_miso <= w_tx_bit;
              r_tx   <= w_tx_shifted;
            end
            if (w_sample) begin
              r_rx     <= w_rx_next;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                if (r_state == ST_CMD) begin
                  r_state <= ST_DATA;
                  r_is_wr <= w_rx_next[7];
                  r_addr  <= w_cmd_addr;
                  r_tx    <= w_rx_next[7] ? 8'h00 : r_regs[w_cmd_addr];
                end else begin
                  if (r_is_wr) begin
                    r_regs[r_addr] <= w_rx_next;
                    r_wr_stb       <= 1'b1;
                    r_wr_addr      <= r_addr;
                    r_wr_data      <= w_rx_next;
                  end
                  // The next byte is loaded now. It shifts out on the
                  // following change edge, before the master samples it.
                  r_addr <= w_addr_inc;
                  r_tx   <= r_is_wr ? 8'h00 : r_regs[w_addr_inc];
                end
              end
            end
          end
        end
      endcase
    end
  end

  assign miso    = r_miso;
  assign miso_oe = r_miso_oe;
  assign regs    = r_regs;
  assign wr_stb  = r_wr_stb;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign busy    = r_busy;

endmodule

// File: tb/tb_spi_slave_regbank.sv
// Self-checking bench for spi_slave_regbank. A bus-functional SPI master
// drives frames. A register-array model predicts the register contents,
// the write strobes and the bytes the master reads back.
module tb_spi_slave_regbank;

  localparam int ADDR_W = 4;
  localparam int NREG   = 16;

  logic clk = 1'b0;
  logic rst, sclk, nss, mosi, cpol, cpha, lsbf;
  logic miso, miso_oe, wr_stb, busy;
  logic [8*NREG-1:0] regs;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0] wr_data;

  spi_slave_regbank #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .nss(nss), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .cpol(cpol), .cpha(cpha), .lsbf(lsbf),
    .regs(regs), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  mem [NREG];
  logic [7:0]  exp_rx [16];
  logic [7:0]  mtx [16];
  logic [7:0]  mrx [16];
  logic [11:0] stb_q [$];
  logic [11:0] exp_q [$];
  int hp = 4;
  int rst_bit = -1;
  logic [8*NREG-1:0] mid_regs;
  logic mid_miso, mid_oe, mid_stb, mid_busy;
  logic [11:0] mid_wr;

  always @(negedge clk) if (wr_stb === 1'b1) stb_q.push_back({wr_addr, wr_data});

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NREG; k++) mem[k] = 8'h00;
    stb_q.delete();
    exp_q.delete();
  endtask

  // Predict the outcome of a frame of nbytes complete bytes held in mtx.
  task automatic model_frame(input int nbytes);
    int a;
    a = int'(mtx[0][3:0]);
    for (int j = 1; j < nbytes; j++) begin
      if (mtx[0][7]) begin
        mem[a] = mtx[j];
        exp_q.push_back({a[3:0], mtx[j]});
      end else begin
        exp_rx[j] = mem[a];
      end
      a = (a + 1) % NREG;
    end
  endtask

  // SPI master. It drives nbits from mtx and records miso into mrx.
  // While nss is low, the mode inputs are scrambled; the DUT must ignore them.
  task automatic spi_xfer(input int mode, input bit lsb, input int nbits);
    bit pol, pha;
    int by, bi;
    logic mb;
    pol = mode[1];
    pha = mode[0];
    sclk = pol; cpol = pol; cpha = pha; lsbf = lsb; mosi = 1'b0;
    wait_clk(4);
    nss = 1'b0;
    wait_clk(hp);
    for (int i = 0; i < nbits; i++) begin
      by = i / 8;
      bi = lsb ? (i % 8) : (7 - i % 8);
      cpol = 1'($urandom); cpha = 1'($urandom); lsbf = 1'($urandom);
      if (!pha) begin
        mosi = mtx[by][bi];
        wait_clk(hp);
        mb = miso;
        sclk = ~pol;
        wait_clk(hp);
        sclk = pol;
      end else begin
        wait_clk(hp);
        sclk = ~pol;
        mosi = mtx[by][bi];
        wait_clk(hp);
        mb = miso;
        sclk = pol;
      end
      mrx[by][bi] = mb;
      if (i == rst_bit) begin
        rst = 1'b1;
        wait_clk(2);
        mid_regs = regs; mid_miso = miso; mid_oe = miso_oe;
        mid_stb = wr_stb; mid_busy = busy; mid_wr = {wr_addr, wr_data};
        rst = 1'b0;
      end
    end
    wait_clk(hp);
    nss = 1'b1;
    mosi = 1'b0;
    wait_clk(3 * hp + 6);
  endtask

  task automatic run_frame(input int mode, input bit lsb, input int nbytes);
    model_frame(nbytes);
    spi_xfer(mode, lsb, nbytes * 8);
  endtask

  task automatic test_reset();
    rst = 1'b1; nss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; lsbf = 1'b0;
    wait_clk(3);
    n_cmp++; if (regs !== '0) begin n_err++; $display("FAIL reset_regs: got %h want 0", regs); end
    n_cmp++; if (miso !== 1'b0) begin n_err++; $display("FAIL reset_miso: got %b want 0", miso); end
    n_cmp++; if (miso_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe: got %b want 0", miso_oe); end
    n_cmp++; if (wr_stb !== 1'b0) begin n_err++; $display("FAIL reset_stb: got %b want 0", wr_stb); end
    n_cmp++; if ({wr_addr, wr_data} !== 12'h000) begin n_err++; $display("FAIL reset_wr: got %h want 000", {wr_addr, wr_data}); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    model_reset();
    wait_clk(6);
  endtask

  task automatic test_write_mode0();
    hp = 4;
    mtx[0] = 8'h83; mtx[1] = 8'h5A;
    run_frame(0, 1'b0, 2);
    n_cmp++; if (regs[8*3 +: 8] !== 8'h5A) begin n_err++; $display("FAIL m0_write_reg3: got %h want 5a", regs[8*3 +: 8]); end
    n_cmp++; if (stb_q.size() !== 1) begin n_err++; $display("FAIL m0_stb_count: got %0d want 1", stb_q.size()); end
    else begin
      n_cmp++; if (stb_q[0] !== 12'h35A) begin n_err++; $display("FAIL m0_stb_data: got %h want 35a", stb_q[0]); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL m0_busy_end: got %b want 0", busy); end
    stb_q.delete(); exp_q.delete();
  endtask

  task automatic test_read_mode3_lsb();
    mtx[0] = 8'h03; mtx[1] = 8'h00;
    run_frame(3, 1'b1, 2);
    n_cmp++; if (mrx[0] !== 8'h00) begin n_err++; $display("FAIL m3_cmd_miso: got %h want 00", mrx[0]); end
    n_cmp++; if (mrx[1] !== exp_rx[1] || exp_rx[1] !== 8'h5A) begin n_err++; $display("FAIL m3_read: got %h want 5a", mrx[1]); end
    n_cmp++; if (stb_q.size() !== 0) begin n_err++; $display("FAIL m3_no_stb: got %0d want 0", stb_q.size()); end
    stb_q.delete(); exp_q.delete();
  endtask

  task automatic test_burst_wrap();
    mtx[0] = 8'h8F; mtx[1] = 8'h11; mtx[2] = 8'h22; mtx[3] = 8'h33;
    run_frame(1, 1'b0, 4);
    n_cmp++; if (regs[8*15 +: 8] !== 8'h11) begin n_err++; $display("FAIL wrap_reg15: got %h want 11", regs[8*15 +: 8]); end
    n_cmp++; if (regs[8*0 +: 8] !== 8'h22) begin n_err++; $display("FAIL wrap_reg0: got %h want 22", regs[8*0 +: 8]); end
    n_cmp++; if (regs[8*1 +: 8] !== 8'h33) begin n_err++; $display("FAIL wrap_reg1: got %h want 33", regs[8*1 +: 8]); end
    n_cmp++; if (stb_q.size() !== 3) begin n_err++; $display("FAIL wrap_stb_count: got %0d want 3", stb_q.size()); end
    else for (int k = 0; k < 3; k++) begin
      n_cmp++; if (stb_q[k] !== exp_q[k]) begin n_err++; $display("FAIL wrap_stb[%0d]: got %h want %h", k, stb_q[k], exp_q[k]); end
    end
    stb_q.delete(); exp_q.delete();
  endtask

  task automatic test_abort();
    mtx[0] = 8'h85; mtx[1] = 8'hA5;
    run_frame(2, 1'b0, 2);
    stb_q.delete(); exp_q.delete();
    mtx[0] = 8'h85; mtx[1] = 8'h3C;
    model_frame(1);
    spi_xfer(2, 1'b0, 13);
    n_cmp++; if (regs[8*5 +: 8] !== mem[5]) begin n_err++; $display("FAIL abort_reg5: got %h want %h", regs[8*5 +: 8], mem[5]); end
    n_cmp++; if (stb_q.size() !== 0) begin n_err++; $display("FAIL abort_no_stb: got %0d want 0", stb_q.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
    stb_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    mtx[0] = 8'h81; mtx[1] = 8'h11;
    run_frame(0, 1'b0, 2);
    stb_q.delete(); exp_q.delete();
    mtx[0] = 8'h82; mtx[1] = 8'h77;
    rst_bit = 10;
    spi_xfer(0, 1'b0, 16);
    rst_bit = -1;
    model_reset();
    n_cmp++; if (mid_regs !== '0) begin n_err++; $display("FAIL midrst_regs: got %h want 0", mid_regs); end
    n_cmp++; if ({mid_miso, mid_oe, mid_stb, mid_busy} !== 4'b0000) begin n_err++; $display("FAIL midrst_ctrl: got %b want 0000", {mid_miso, mid_oe, mid_stb, mid_busy}); end
    n_cmp++; if (mid_wr !== 12'h000) begin n_err++; $display("FAIL midrst_wr: got %h want 000", mid_wr); end
    n_cmp++; if (regs[8*2 +: 8] !== 8'h00) begin n_err++; $display("FAIL midrst_ignored: got %h want 00", regs[8*2 +: 8]); end
    n_cmp++; if (stb_q.size() !== 0) begin n_err++; $display("FAIL midrst_no_stb: got %0d want 0", stb_q.size()); end
    stb_q.delete();
    mtx[0] = 8'h81; mtx[1] = 8'hC3;
    run_frame(0, 1'b0, 2);
    n_cmp++; if (regs[8*1 +: 8] !== 8'hC3) begin n_err++; $display("FAIL midrst_next: got %h want c3", regs[8*1 +: 8]); end
    n_cmp++; if (stb_q.size() !== 1) begin n_err++; $display("FAIL midrst_next_stb: got %0d want 1", stb_q.size()); end
    stb_q.delete(); exp_q.delete();
  endtask

  // In each mode, write a random burst, then read it back in the same mode.
  // Set use_hp4 for a half-period of 4 clk; otherwise it is random, 4..8.
  task automatic test_modes(input bit use_hp4);
    int a, n;
    for (int mode = 0; mode < 4; mode++) begin
      hp = use_hp4 ? 4 : int'($urandom_range(4, 8));
      a = int'($urandom_range(0, NREG - 1));
      n = int'($urandom_range(1, 5));
      mtx[0] = {1'b1, 3'($urandom), a[3:0]};
      for (int j = 1; j <= n; j++) mtx[j] = 8'($urandom);
      run_frame(mode, 1'($urandom), n + 1);
      n_cmp++; if (stb_q.size() !== exp_q.size()) begin n_err++; $display("FAIL modes_stb_count m%0d: got %0d want %0d", mode, stb_q.size(), exp_q.size()); end
      else for (int k = 0; k < exp_q.size(); k++) begin
        n_cmp++; if (stb_q[k] !== exp_q[k]) begin n_err++; $display("FAIL modes_stb m%0d[%0d]: got %h want %h", mode, k, stb_q[k], exp_q[k]); end
      end
      stb_q.delete(); exp_q.delete();
      mtx[0] = {1'b0, 3'($urandom), a[3:0]};
      for (int j = 1; j <= n; j++) mtx[j] = 8'($urandom);
      run_frame(mode, 1'($urandom), n + 1);
      n_cmp++; if (mrx[0] !== 8'h00) begin n_err++; $display("FAIL modes_cmd_miso m%0d: got %h want 00", mode, mrx[0]); end
      for (int j = 1; j <= n; j++) begin
        n_cmp++; if (mrx[j] !== exp_rx[j]) begin n_err++; $display("FAIL modes_read m%0d[%0d]: got %h want %h", mode, j, mrx[j], exp_rx[j]); end
      end
      n_cmp++; if (stb_q.size() !== 0) begin n_err++; $display("FAIL modes_read_stb m%0d: got %0d want 0", mode, stb_q.size()); end
      stb_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_final_regs();
    for (int k = 0; k < NREG; k++) begin
      n_cmp++; if (regs[8*k +: 8] !== mem[k]) begin n_err++; $display("FAIL final_reg[%0d]: got %h want %h", k, regs[8*k +: 8], mem[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_write_mode0();
    test_read_mode3_lsb();
    test_burst_wrap();
    test_abort();
    test_reset_midframe();
    test_modes(1'b1);
    test_modes(1'b0);
    test_final_regs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_regbank.md
SPI_SLAVE_REGBANK -- requirements
Module: spi_slave_regbank

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning register address width (2^ADDR_W 8-bit registers; legal range 1..7).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on sclk/nss/mosi (minimum 2).
REQ-003 SHALL have port clk  input  1  meaning system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, asynchronous, active-high.
REQ-005 SHALL have ports sclk, nss, mosi  input  1 each  meaning SPI bus from the master, asynchronous to clk; nss is active-low.
REQ-006 SHALL have port miso  output  1  meaning serial data to the master.
REQ-007 SHALL have port miso_oe  output  1  meaning miso drive enable, high only while the synchronized nss is low.
REQ-008 SHALL have ports cpol, cpha, lsbf  input  1 each  meaning clock polarity, clock phase and LSB-first select, captured at nss falling.
REQ-009 SHALL have port regs  output  8*2^ADDR_W  meaning flattened register file; register k occupies bits [8k+7:8k].
REQ-010 SHALL have ports wr_stb (1), wr_addr (ADDR_W), wr_data (8), all outputs, meaning a one-clk pulse with the address and data of each committed write.
REQ-011 SHALL have port busy  output  1  meaning the state machine is not in IDLE.

Function
REQ-012 SHALL pass sclk, nss and mosi through SYNC_STAGES flip-flops and detect edges on the synchronized copies only.
REQ-013 SHALL support an sclk half-period of at least 4 clk cycles in all modes.
REQ-014 Sample edge SHALL be the leading edge when cpha=0 and the trailing edge when cpha=1; leading edge = rising if cpol=0, falling if cpol=1; miso SHALL change on the opposite edge.
REQ-015 Bit order SHALL be MSB-first when lsbf=0 and LSB-first when lsbf=1, for both received and transmitted bytes.
REQ-016 Frame format: byte 0 = command (bit7 = 1 write, 0 read; bits[ADDR_W-1:0] = start address; remaining bits ignored); bytes 1..n = data.
REQ-017 States: IDLE -> CMD on nss falling; CMD -> DATA after 8 samples; DATA -> DATA after every 8 samples; any state -> IDLE on nss rising.
REQ-018 On a write frame, each completed data byte SHALL update regs[addr] and pulse wr_stb exactly one clk, within 2 clk after the 8th sample edge.
REQ-019 On a read frame, regs[addr] SHALL be loaded into the transmit shifter before the first miso change edge of the next byte; when cpha=0, the first bit SHALL be driven before the first leading edge.
REQ-020 miso SHALL output 0 throughout the command byte.
REQ-021 After each data byte, addr SHALL increment; 2^ADDR_W-1 wraps to 0.
REQ-022 nss rising mid-byte SHALL discard the partial byte; no write and no wr_stb.
REQ-023 cpol/cpha/lsbf changes while nss is low SHALL be ignored until the next frame.
REQ-024 A write to an address in the same frame it is read SHALL return the pre-write value for a byte already loaded into the shifter.

Reset
REQ-025 While rst is high: regs = 0, miso = 0, miso_oe = 0, wr_stb = 0, wr_addr = 0, wr_data = 0, busy = 0, state = IDLE, synchronizers cleared.
REQ-026 After rst deasserts with nss already low, the block SHALL ignore that frame and wait for nss high before accepting a new frame.

Verification
REQ-027 Mode 0, MSB-first, frame 0x83,0x5A -> regs[3]=0x5A; one wr_stb with wr_addr=3, wr_data=0x5A.
REQ-028 Mode 3, LSB-first, frame 0x03,0x00 after REQ-027 -> master receives 0x00 then 0x5A; no wr_stb.
REQ-029 Mode 1, burst write 0x8F,0x11,0x22,0x33 (ADDR_W=4) -> regs[15]=0x11, regs[0]=0x22, regs[1]=0x33 (wrap); three wr_stb pulses.
REQ-030 Mode 2, cmd 0x85 then nss raised after 5 data bits -> regs[5] unchanged; no wr_stb; busy returns to 0.
REQ-031 rst pulsed mid-frame while nss is low -> all outputs at reset values; that frame ignored; next full frame 0x81,0xC3 -> regs[1]=0xC3.
REQ-032 All four modes at sclk half-period = 4 clk -> read data bit-exact vs. the values written.
